vmem_arbiter: RTL

Two-port arbiter sharing the single-ported video memory between the HDMI display fetcher (palette and pixel reads) and the CPU (reads and byte-masked writes). It sits between the display block's `vmem_*` port, the CPU's video-memory port and one synchronous 32-bit block RAM. It grants one access every two cycles with round-robin fairness. Display read data is byte-aligned, so the fetcher receives the addressed byte in `[7:0]`.

---
 rtl/vmem_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - round-robin arbiter sharing one synchronous 32-bit RAM between display and CPU
module vmem_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       d_rdata,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [3:0]        c_wstrb,
  input  logic [31:0]       c_wdata,
  output logic [31:0]       c_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic       owner;
  logic       last;
  logic [1:0] shift;
  logic       pick_c;
  logic       pick_d;
  logic       win;
  logic       unused_c_lo;

  // CPU lane offset never matters: CPU sees whole words.
  assign unused_c_lo = ^c_addr[1:0];

  // On a tie the requester that did not hold the last grant wins.
  always_comb begin
    pick_c = c_valid && (!d_valid || !last);
    pick_d = d_valid && !pick_c;
    win    = (state == IDLE) && !rst && (pick_c || pick_d);
  end

  // Gating with rst keeps the RAM and the requesters quiet while reset is held.
  assign mem_en    = win;
  assign mem_we    = (win && pick_c) ? c_wstrb : 4'b0000;
  assign mem_addr  = pick_c ? c_addr[ADDR_W-1:2] : d_addr[ADDR_W-1:2];
  assign mem_wdata = c_wdata;

  assign d_ready = (state == BUSY) && !owner && !rst;
  assign c_ready = (state == BUSY) &&  owner && !rst;
  assign d_rdata = mem_rdata >> {shift, 3'b000};
  assign c_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      shift <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (pick_c || pick_d) begin
            owner <= pick_c;
            last  <= pick_c;
            shift <= d_addr[1:0];
            state <= BUSY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
